// File: rtl/btn_reader.sv
// CPU-readable 4-bit push-button port: 2-FF sync, per-bit debounce, sticky
// press flags with clear-on-read, and a level interrupt while any flag is pending.
module btn_reader #(
  parameter logic [15:0] BASE_ADDR  = 16'hD01A,
  parameter int          DEB_CYCLES = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Abus,
  input  logic        re,
  input  logic [3:0]  btn_in,
  output logic [7:0]  Data_Out,
  output logic        dout_en,
  output logic        irq
);

  localparam int            CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [3:0]    stable_q, stable_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    flags_q, flags_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          dout_en_q, dout_en_d;
  logic          irq_q, irq_d;

  logic [3:0] pressed;
  logic [3:0] press_evt;
  logic       hit;
  logic       rd_flags;

  always_comb begin
    sync1_d    = btn_in;
    sync2_d    = sync1_q;
    pressed    = sync2_q ^ {4{ACTIVE_LOW}};
    stable_d   = stable_q;
    press_evt  = 4'b0000;
    hit        = 1'b0;
    rd_flags   = 1'b0;
    flags_d    = flags_q;
    data_out_d = 8'h00;
    dout_en_d  = 1'b0;
    irq_d      = 1'b0;

    // A bit is accepted only after DEB_CYCLES consecutive disagreeing samples;
    // any agreeing sample restarts the count, so the counter cannot wrap.
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (pressed[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = pressed[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end

    press_evt = stable_d & ~stable_q;
    hit       = re && (Abus[15:1] == BASE_ADDR[15:1]);
    rd_flags  = hit && Abus[0];

    // Set has priority over the read-clear so a coincident press is kept.
    flags_d = (flags_q & ~{4{rd_flags}}) | press_evt;

    dout_en_d = hit;
    if (hit) begin
      data_out_d = Abus[0] ? {4'b0000, flags_q} : {4'b0000, stable_q};
    end

    irq_d = |flags_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 4'b0000;
      sync2_q    <= 4'b0000;
      stable_q   <= 4'b0000;
      flags_q    <= 4'b0000;
      data_out_q <= 8'h00;
      dout_en_q  <= 1'b0;
      irq_q      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      flags_q    <= flags_d;
      data_out_q <= data_out_d;
      dout_en_q  <= dout_en_d;
      irq_q      <= irq_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign Data_Out = data_out_q;
  assign dout_en  = dout_en_q;
  assign irq      = irq_q;

endmodule
